ysyx_22040088_pc_sequencer: RTL and testbench

// - Multicycle fetch/PC controller for the NPC core. Owns the architectural PC register and sequences

---
 rtl/ysyx_22040088_pc_sequencer_pkg.sv | 38 +++
 rtl/ysyx_22040088_brsel_decode.sv | 28 ++
 rtl/ysyx_22040088_pc_sequencer.sv | 133 +++++++++++++
 tb/tb_ysyx_22040088_pc_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040088_pc_sequencer_pkg.sv
// Shared definitions for the NPC fetch/PC sequencer: FSM states, branch-type
// codes, error codes and the one-hot next-PC mux selects used by gennextpc.
package ysyx_22040088_defs;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_EXEC   = 3'd4,
        ST_UPDATE = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [2:0] BR_SEQ  = 3'd0;
    localparam logic [2:0] BR_JAL  = 3'd1;
    localparam logic [2:0] BR_JALR = 3'd2;
    localparam logic [2:0] BR_BEQ  = 3'd3;
    localparam logic [2:0] BR_BNE  = 3'd4;
    localparam logic [2:0] BR_BLT  = 3'd5;
    localparam logic [2:0] BR_BGE  = 3'd6;
    localparam logic [2:0] BR_ILL  = 3'd7;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

    // Bit positions match the BR_* codes so a taken branch selects bit[type].
    localparam logic [6:0] SEL_PCADD = 7'b0000001;
    localparam logic [6:0] SEL_JAL   = 7'b0000010;
    localparam logic [6:0] SEL_JALR  = 7'b0000100;
    localparam logic [6:0] SEL_BEQ   = 7'b0001000;
    localparam logic [6:0] SEL_BNE   = 7'b0010000;
    localparam logic [6:0] SEL_BLT   = 7'b0100000;
    localparam logic [6:0] SEL_BGE   = 7'b1000000;

endpackage

// File: rtl/ysyx_22040088_brsel_decode.sv
// Maps the EXU branch type and condition result onto the one-hot next-PC
// select; unknown types fall back to pcadd and raise the illegal flag.
module ysyx_22040088_brsel_decode
    import ysyx_22040088_defs::*;
(
    input  logic [2:0] br_type,
    input  logic       br_taken,
    output logic [6:0] sel,
    output logic       illegal
);

    always_comb begin
        sel     = SEL_PCADD;
        illegal = 1'b0;
        case (br_type)
            BR_SEQ:  sel = SEL_PCADD;
            BR_JAL:  sel = SEL_JAL;
            BR_JALR: sel = SEL_JALR;
            BR_BEQ:  if (br_taken) sel = SEL_BEQ;
            BR_BNE:  if (br_taken) sel = SEL_BNE;
            BR_BLT:  if (br_taken) sel = SEL_BLT;
            BR_BGE:  if (br_taken) sel = SEL_BGE;
            BR_ILL:  illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_22040088_pc_sequencer.sv
// Multicycle fetch/PC controller: owns the architectural PC and walks each
// instruction through fetch, issue, execute-wait and PC update.
module ysyx_22040088_pc_sequencer
    import ysyx_22040088_defs::*;
#(
    parameter logic [63:0] RESET_PC      = 64'h8000_0000,
    parameter int          FETCH_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    output logic [63:0] ifu_req_addr,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] pc,
    input  logic        ex_done,
    input  logic [2:0]  ex_br_type,
    input  logic        ex_br_taken,
    input  logic        ex_halt,
    output logic [6:0]  sel_nextpc,
    input  logic [63:0] nextpc,
    output logic [63:0] retire_cnt,
    output logic        halted,
    output logic [1:0]  err_code,
    output logic [2:0]  state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid, address and data stay stable until then.

    localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [63:0] pc_q;
    logic [31:0] inst_q;
    logic [63:0] retire_q;
    logic [1:0]  err_q;
    logic [6:0]  sel_q;
    logic        ill_q;
    logic [7:0]  cnt_q;

    logic [6:0]  dec_sel;
    logic        dec_ill;
    logic        timeout_hit;
    logic        misaligned;

    ysyx_22040088_brsel_decode u_brsel (
        .br_type  (ex_br_type),
        .br_taken (ex_br_taken),
        .sel      (dec_sel),
        .illegal  (dec_ill)
    );

    // cnt_q holds the number of WAIT cycles already spent, so the last
    // allowed WAIT cycle is the one where it reads FETCH_TIMEOUT-1.
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);
    assign misaligned  = (nextpc[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_FETCH;
            ST_FETCH:  if (ifu_req_ready) state_d = ST_WAIT;
            ST_WAIT: begin
                if (ifu_rsp_valid)    state_d = ST_ISSUE;
                else if (timeout_hit) state_d = ST_HALT;
            end
            ST_ISSUE:  if (inst_ready) state_d = ST_EXEC;
            ST_EXEC:   if (ex_done) state_d = ex_halt ? ST_HALT : ST_UPDATE;
            ST_UPDATE: state_d = (misaligned || ill_q) ? ST_HALT : ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            retire_q <= '0;
            err_q    <= ERR_NONE;
            sel_q    <= SEL_PCADD;
            ill_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_FETCH: if (ifu_req_ready) cnt_q <= '0;
                ST_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (ifu_rsp_valid)
                        inst_q <= ifu_rsp_inst;
                    else if (timeout_hit && err_q == ERR_NONE)
                        err_q <= ERR_TIMEOUT;
                end
                ST_EXEC: begin
                    if (ex_done) begin
                        sel_q <= dec_sel;
                        ill_q <= dec_ill;
                        if (ex_halt) retire_q <= retire_q + 64'd1;
                    end
                end
                ST_UPDATE: begin
                    retire_q <= retire_q + 64'd1;
                    if (misaligned) begin
                        if (err_q == ERR_NONE) err_q <= ERR_MISALIGN;
                    end else begin
                        pc_q <= nextpc;
                        if (ill_q && err_q == ERR_NONE) err_q <= ERR_ILLEGAL;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ifu_req_valid = (state_q == ST_FETCH);
    assign ifu_req_addr  = pc_q;
    assign inst_valid    = (state_q == ST_ISSUE);
    assign inst          = inst_q;
    assign pc            = pc_q;
    assign sel_nextpc    = sel_q;
    assign retire_cnt    = retire_q;
    assign halted        = (state_q == ST_HALT);
    assign err_code      = err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_ysyx_22040088_pc_sequencer.sv
// Directed bench for the PC sequencer: fetch addresses are queued as expected
// values when the next PC is driven and popped when the DUT requests a fetch.
module tb_ysyx_22040088_pc_sequencer;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          TO       = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ifu_req_valid;
    logic        ifu_req_ready = 1'b0;
    logic [63:0] ifu_req_addr;
    logic        ifu_rsp_valid = 1'b0;
    logic [31:0] ifu_rsp_inst = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        ex_done = 1'b0;
    logic [2:0]  ex_br_type = '0;
    logic        ex_br_taken = 1'b0;
    logic        ex_halt = 1'b0;
    logic [6:0]  sel_nextpc;
    logic [63:0] nextpc = '0;
    logic [63:0] retire_cnt;
    logic        halted;
    logic [1:0]  err_code;
    logic [2:0]  state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_fetch  = 0;
    int next_gap    = 0;
    logic [63:0] model_retire = '0;
    logic [63:0] exp_q[$];

    ysyx_22040088_pc_sequencer #(
        .RESET_PC      (RESET_PC),
        .FETCH_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_addr  (ifu_req_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_inst  (ifu_rsp_inst),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .pc            (pc),
        .ex_done       (ex_done),
        .ex_br_type    (ex_br_type),
        .ex_br_taken   (ex_br_taken),
        .ex_halt       (ex_halt),
        .sel_nextpc    (sel_nextpc),
        .nextpc        (nextpc),
        .retire_cnt    (retire_cnt),
        .halted        (halted),
        .err_code      (err_code),
        .state_dbg     (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_valid"},  ifu_req_valid, 1'b0);
        check({tag, "_inst_valid"}, inst_valid, 1'b0);
        check({tag, "_pc"},         pc, RESET_PC);
        check({tag, "_inst"},       inst, 32'h0);
        check({tag, "_retire"},     retire_cnt, 64'h0);
        check({tag, "_halted"},     halted, 1'b0);
        check({tag, "_err"},        err_code, 2'd0);
        check({tag, "_sel"},        sel_nextpc, 7'b0000001);
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then releases.
    task automatic reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        inst_ready    = 1'b0;
        ex_done       = 1'b0;
        ex_halt       = 1'b0;
        #1;
        check_reset_vals(tag);
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        model_retire = '0;
        next_gap     = 0;
    endtask

    // Driver: wait (bounded) for a fetch request and compare its address.
    task automatic fetch_step();
        int n = 0;
        logic [63:0] e;
        while (!ifu_req_valid && n < 20) begin
            tick();
            n++;
        end
        check("fetch_seen", ifu_req_valid, 1'b1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        check("fetch_addr", ifu_req_addr, e);
        if (next_gap > 0) check("cycles_per_instr", 64'(cyc - last_fetch), 64'(next_gap));
        last_fetch = cyc;
    endtask

    // Driver: one full instruction with zero-wait IFU/EXU and an optional decoder stall.
    task automatic run_instr(input string tag, input logic [31:0] iw, input logic [2:0] bt,
                             input logic tk, input logic hlt, input logic [63:0] npc,
                             input logic [6:0] exp_sel, input int stall,
                             input logic [63:0] exp_pc, input logic [1:0] exp_err,
                             input logic exp_halt);
        logic [63:0] pc_before;
        fetch_step();
        pc_before = ifu_req_addr;
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = iw;
        tick();
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = '0;
        check({tag, "_inst_valid"}, inst_valid, 1'b1);
        check({tag, "_inst"},       inst, iw);
        for (int i = 0; i < stall; i++) begin
            ex_done       = i[0];
            ifu_rsp_valid = ~i[0];
            ifu_rsp_inst  = 32'hdead_beef;
            tick();
            check({tag, "_stall_valid"}, inst_valid, 1'b1);
            check({tag, "_stall_inst"},  inst, iw);
            check({tag, "_stall_pc"},    pc, pc_before);
        end
        ex_done       = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = '0;
        inst_ready    = 1'b1;
        tick();
        inst_ready = 1'b0;
        check({tag, "_exec_valid"}, inst_valid, 1'b0);
        ex_done     = 1'b1;
        ex_br_type  = bt;
        ex_br_taken = tk;
        ex_halt     = hlt;
        tick();
        ex_done     = 1'b0;
        ex_halt     = 1'b0;
        ex_br_type  = '0;
        ex_br_taken = 1'b0;
        if (!hlt) begin
            check({tag, "_sel"}, sel_nextpc, exp_sel);
            nextpc = npc;
            tick();
        end
        model_retire = model_retire + 64'd1;
        check({tag, "_pc"},     pc, exp_pc);
        check({tag, "_retire"}, retire_cnt, model_retire);
        check({tag, "_err"},    err_code, exp_err);
        check({tag, "_halted"}, halted, exp_halt);
        if (!exp_halt) exp_q.push_back(exp_pc);
        next_gap = 5 + stall;
    endtask

    // Directed sequence
    initial begin
        reset_pulse("por");

        run_instr("addi", 32'h0000_0013, 3'd0, 1'b0, 1'b0, 64'h8000_0004, 7'b0000001, 0,
                  64'h8000_0004, 2'd0, 1'b0);
        run_instr("beq_t", 32'h0000_0463, 3'd3, 1'b1, 1'b0, 64'h8000_0100, 7'b0001000, 0,
                  64'h8000_0100, 2'd0, 1'b0);
        run_instr("beq_nt", 32'h0000_0463, 3'd3, 1'b0, 1'b0, 64'h8000_0104, 7'b0000001, 10,
                  64'h8000_0104, 2'd0, 1'b0);
        run_instr("jal", 32'h0fc0_006f, 3'd1, 1'b0, 1'b0, 64'h8000_0200, 7'b0000010, 0,
                  64'h8000_0200, 2'd0, 1'b0);
        run_instr("bne_t", 32'h1000_1063, 3'd4, 1'b1, 1'b0, 64'h8000_0300, 7'b0010000, 0,
                  64'h8000_0300, 2'd0, 1'b0);
        run_instr("blt_t", 32'h1000_4063, 3'd5, 1'b1, 1'b0, 64'h8000_0400, 7'b0100000, 0,
                  64'h8000_0400, 2'd0, 1'b0);
        run_instr("bge_t", 32'h1000_5063, 3'd6, 1'b1, 1'b0, 64'h8000_0500, 7'b1000000, 0,
                  64'h8000_0500, 2'd0, 1'b0);
        run_instr("bge_nt", 32'h1000_5063, 3'd6, 1'b0, 1'b0, 64'h8000_0504, 7'b0000001, 0,
                  64'h8000_0504, 2'd0, 1'b0);
        run_instr("ebreak", 32'h0010_0073, 3'd0, 1'b0, 1'b1, 64'h8000_0508, 7'b0000001, 0,
                  64'h8000_0504, 2'd0, 1'b1);

        // HALT is absorbing and requests stay low
        for (int i = 0; i < 3; i++) begin
            ifu_req_ready = 1'b1;
            ex_done       = 1'b1;
            tick();
            check("halt_req_low", ifu_req_valid, 1'b0);
            check("halt_sticky",  halted, 1'b1);
        end
        ifu_req_ready = 1'b0;
        ex_done       = 1'b0;
        check("halt_retire", retire_cnt, 64'd9);

        reset_pulse("rst_in_halt");
        run_instr("jalr_mis", 32'h0000_8067, 3'd2, 1'b0, 1'b0, 64'h8000_0102, 7'b0000100, 0,
                  64'h8000_0000, 2'd1, 1'b1);

        reset_pulse("rst_after_mis");
        run_instr("illegal", 32'hffff_ffff, 3'd7, 1'b0, 1'b0, 64'h8000_0004, 7'b0000001, 0,
                  64'h8000_0004, 2'd3, 1'b1);

        // IFU never responds: halt exactly TO cycles after the accept edge
        reset_pulse("rst_before_to");
        fetch_step();
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        repeat (TO - 1) tick();
        check("to_not_yet", halted, 1'b0);
        tick();
        check("to_halted",   halted, 1'b1);
        check("to_err",      err_code, 2'd2);
        check("to_req_low",  ifu_req_valid, 1'b0);

        // Response on the timeout cycle wins
        reset_pulse("rst_in_to_halt");
        fetch_step();
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        repeat (TO - 1) tick();
        ifu_rsp_valid = 1'b1;
        ifu_rsp_inst  = 32'h0000_0013;
        tick();
        ifu_rsp_valid = 1'b0;
        ifu_rsp_inst  = '0;
        check("to_edge_issue",  inst_valid, 1'b1);
        check("to_edge_inst",   inst, 32'h0000_0013);
        check("to_edge_halted", halted, 1'b0);
        check("to_edge_err",    err_code, 2'd0);

        // Reset during WAIT abandons the fetch and restarts at RESET_PC
        reset_pulse("rst_pre_wait");
        fetch_step();
        ifu_req_ready = 1'b1;
        tick();
        ifu_req_ready = 1'b0;
        repeat (3) tick();
        reset_pulse("rst_in_wait");
        run_instr("restart", 32'h0000_0013, 3'd0, 1'b0, 1'b0, 64'h8000_0004, 7'b0000001, 0,
                  64'h8000_0004, 2'd0, 1'b0);
        fetch_step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
